// File: rtl/tlul_pkg.sv
// Shared TL-UL opcode constants and interconnect FSM state encoding.
package tlul_pkg;

  localparam logic [2:0] OP_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] OP_GET              = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA  = 3'd1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_D,
    RESP
  } tlul_state_e;

  function automatic logic opcode_legal(input logic [2:0] opcode);
    return (opcode == OP_PUT_FULL_DATA) || (opcode == OP_PUT_PARTIAL_DATA) ||
           (opcode == OP_GET);
  endfunction

endpackage

// File: rtl/tlul_rr_arbiter.sv
// 3-way round-robin arbiter: one-hot grant from the priority pointer,
// pointer moves past the granted master when the grant is accepted.
module tlul_rr_arbiter (
  input  logic       clk_100,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] gnt,
  output logic [1:0] gnt_idx
);

  logic [1:0] ptr;
  logic [1:0] first;
  logic [1:0] second;
  logic [1:0] third;

  always_comb begin
    first   = 2'd0;
    second  = 2'd1;
    third   = 2'd2;
    case (ptr)
      2'd1: begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd2: begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: ;
    endcase
    gnt     = '0;
    gnt_idx = 2'd0;
    if (req[first])       gnt_idx = first;
    else if (req[second]) gnt_idx = second;
    else if (req[third])  gnt_idx = third;
    if (|req) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      ptr <= 2'd0;
    end else if (advance && (|req)) begin
      ptr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end
  end

endmodule

// File: rtl/tlul_interconnect.sv
// TL-UL 3:1 interconnect: round-robin A arbitration, single-window decode,
// local error responses for misses, one outstanding transaction.
//
// state  | meaning
// IDLE   | arbitrate and accept one A request
// ISSUE  | present captured request downstream
// WAIT_D | wait for downstream D response
// RESP   | present response to the granted master
module tlul_interconnect
  import tlul_pkg::*;
#(
  parameter int unsigned NUM_MASTERS  = 3,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned SRC_WIDTH    = 2,
  parameter int unsigned SINK_WIDTH   = 1,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK = 32'hFFFF_F000
) (
  input  logic                                clk_100,
  input  logic                                reset,
  input  logic [NUM_MASTERS-1:0]              master_a_valid,
  output logic [NUM_MASTERS-1:0]              master_a_ready,
  input  logic [NUM_MASTERS*OPCODE_WIDTH-1:0] master_a_opcode,
  input  logic [NUM_MASTERS*PARAM_WIDTH-1:0]  master_a_param,
  input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]   master_a_size,
  input  logic [NUM_MASTERS*SRC_WIDTH-1:0]    master_a_source,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   master_a_address,
  input  logic [NUM_MASTERS*MASK_WIDTH-1:0]   master_a_mask,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   master_a_data,
  output logic [NUM_MASTERS-1:0]              master_d_valid,
  input  logic [NUM_MASTERS-1:0]              master_d_ready,
  output logic [NUM_MASTERS*OPCODE_WIDTH-1:0] master_d_opcode,
  output logic [NUM_MASTERS*PARAM_WIDTH-1:0]  master_d_param,
  output logic [NUM_MASTERS*SIZE_WIDTH-1:0]   master_d_size,
  output logic [NUM_MASTERS*SRC_WIDTH-1:0]    master_d_source,
  output logic [NUM_MASTERS*SINK_WIDTH-1:0]   master_d_sink,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]   master_d_data,
  output logic [NUM_MASTERS-1:0]              master_d_error,
  output logic                                slave_a_valid,
  input  logic                                slave_a_ready,
  output logic [OPCODE_WIDTH-1:0]             slave_a_opcode,
  output logic [PARAM_WIDTH-1:0]              slave_a_param,
  output logic [SIZE_WIDTH-1:0]               slave_a_size,
  output logic [SRC_WIDTH-1:0]                slave_a_source,
  output logic [ADDR_WIDTH-1:0]               slave_a_address,
  output logic [MASK_WIDTH-1:0]               slave_a_mask,
  output logic [DATA_WIDTH-1:0]               slave_a_data,
  input  logic                                slave_d_valid,
  output logic                                slave_d_ready,
  input  logic [OPCODE_WIDTH-1:0]             slave_d_opcode,
  input  logic [PARAM_WIDTH-1:0]              slave_d_param,
  input  logic [SIZE_WIDTH-1:0]               slave_d_size,
  input  logic [SRC_WIDTH-1:0]                slave_d_source,
  input  logic [SINK_WIDTH-1:0]               slave_d_sink,
  input  logic [DATA_WIDTH-1:0]               slave_d_data,
  input  logic                                slave_d_error
);

  tlul_state_e state, state_next;

  logic [NUM_MASTERS-1:0] gnt;
  logic [1:0]             gnt_idx;
  logic [1:0]             grant_q;
  logic                   idle_accept;
  logic                   sel_hit;

  logic [OPCODE_WIDTH-1:0] sel_opcode;
  logic [PARAM_WIDTH-1:0]  sel_param;
  logic [SIZE_WIDTH-1:0]   sel_size;
  logic [SRC_WIDTH-1:0]    sel_source;
  logic [ADDR_WIDTH-1:0]   sel_address;
  logic [MASK_WIDTH-1:0]   sel_mask;
  logic [DATA_WIDTH-1:0]   sel_data;

  logic [OPCODE_WIDTH-1:0] req_opcode;
  logic [PARAM_WIDTH-1:0]  req_param;
  logic [SIZE_WIDTH-1:0]   req_size;
  logic [SRC_WIDTH-1:0]    req_source;
  logic [ADDR_WIDTH-1:0]   req_address;
  logic [MASK_WIDTH-1:0]   req_mask;
  logic [DATA_WIDTH-1:0]   req_data;

  logic [OPCODE_WIDTH-1:0] rsp_opcode;
  logic [PARAM_WIDTH-1:0]  rsp_param;
  logic [SIZE_WIDTH-1:0]   rsp_size;
  logic [SRC_WIDTH-1:0]    rsp_source;
  logic [SINK_WIDTH-1:0]   rsp_sink;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_error;

  tlul_rr_arbiter u_arbiter (
    .clk_100 (clk_100),
    .reset   (reset),
    .req     (master_a_valid),
    .advance (idle_accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Gated by reset so master_a_ready is low while reset is held, even in IDLE.
  assign idle_accept    = (state == IDLE) && reset && (|master_a_valid);
  assign master_a_ready = idle_accept ? gnt : '0;

  assign sel_opcode  = master_a_opcode[gnt_idx*OPCODE_WIDTH +: OPCODE_WIDTH];
  assign sel_param   = master_a_param[gnt_idx*PARAM_WIDTH +: PARAM_WIDTH];
  assign sel_size    = master_a_size[gnt_idx*SIZE_WIDTH +: SIZE_WIDTH];
  assign sel_source  = master_a_source[gnt_idx*SRC_WIDTH +: SRC_WIDTH];
  assign sel_address = master_a_address[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_mask    = master_a_mask[gnt_idx*MASK_WIDTH +: MASK_WIDTH];
  assign sel_data    = master_a_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_hit     = ((sel_address & SLAVE_MASK) == SLAVE_BASE) && opcode_legal(sel_opcode);

  assign slave_a_opcode  = req_opcode;
  assign slave_a_param   = req_param;
  assign slave_a_size    = req_size;
  assign slave_a_source  = req_source;
  assign slave_a_address = req_address;
  assign slave_a_mask    = req_mask;
  assign slave_a_data    = req_data;

  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    slave_a_valid   = 1'b0;
    slave_d_ready   = 1'b0;
    master_d_valid  = '0;
    master_d_opcode = '0;
    master_d_param  = '0;
    master_d_size   = '0;
    master_d_source = '0;
    master_d_sink   = '0;
    master_d_data   = '0;
    master_d_error  = '0;
    case (state)
      IDLE: begin
        if (idle_accept) state_next = sel_hit ? ISSUE : RESP;
      end
      ISSUE: begin
        slave_a_valid = 1'b1;
        if (slave_a_ready) state_next = WAIT_D;
      end
      WAIT_D: begin
        slave_d_ready = 1'b1;
        if (slave_d_valid) state_next = RESP;
      end
      RESP: begin
        master_d_valid[grant_q]                                 = 1'b1;
        master_d_opcode[grant_q*OPCODE_WIDTH +: OPCODE_WIDTH]  = rsp_opcode;
        master_d_param[grant_q*PARAM_WIDTH +: PARAM_WIDTH]     = rsp_param;
        master_d_size[grant_q*SIZE_WIDTH +: SIZE_WIDTH]        = rsp_size;
        master_d_source[grant_q*SRC_WIDTH +: SRC_WIDTH]        = rsp_source;
        master_d_sink[grant_q*SINK_WIDTH +: SINK_WIDTH]        = rsp_sink;
        master_d_data[grant_q*DATA_WIDTH +: DATA_WIDTH]        = rsp_data;
        master_d_error[grant_q]                                 = rsp_error;
        if (master_d_ready[grant_q]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      grant_q     <= '0;
      req_opcode  <= '0;
      req_param   <= '0;
      req_size    <= '0;
      req_source  <= '0;
      req_address <= '0;
      req_mask    <= '0;
      req_data    <= '0;
      rsp_opcode  <= '0;
      rsp_param   <= '0;
      rsp_size    <= '0;
      rsp_source  <= '0;
      rsp_sink    <= '0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
    end else if (idle_accept) begin
      grant_q     <= gnt_idx;
      req_opcode  <= sel_opcode;
      req_param   <= sel_param;
      req_size    <= sel_size;
      req_source  <= sel_source;
      req_address <= sel_address;
      req_mask    <= sel_mask;
      req_data    <= sel_data;
      // Misses and illegal opcodes are answered locally from RESP.
      if (!sel_hit) begin
        rsp_opcode <= (sel_opcode == OP_GET) ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
        rsp_param  <= '0;
        rsp_size   <= sel_size;
        rsp_source <= sel_source;
        rsp_sink   <= '0;
        rsp_data   <= '0;
        rsp_error  <= 1'b1;
      end
    end else if ((state == WAIT_D) && slave_d_valid) begin
      rsp_opcode <= slave_d_opcode;
      rsp_param  <= slave_d_param;
      rsp_size   <= slave_d_size;
      rsp_source <= slave_d_source;
      rsp_sink   <= slave_d_sink;
      rsp_data   <= slave_d_data;
      rsp_error  <= slave_d_error;
    end
  end

endmodule

// File: tb/tb_tlul_interconnect.sv
// Scoreboard bench for tlul_interconnect: expected A forwards and D responses
// are queued as requests are driven and popped as the DUT produces them.
module tb_tlul_interconnect;

  logic        clk_100 = 1'b0;
  logic        reset   = 1'b0;
  logic [2:0]  master_a_valid, master_a_ready;
  logic [8:0]  master_a_opcode, master_a_param, master_a_size;
  logic [5:0]  master_a_source;
  logic [95:0] master_a_address, master_a_data;
  logic [11:0] master_a_mask;
  logic [2:0]  master_d_valid, master_d_ready;
  logic [8:0]  master_d_opcode, master_d_param, master_d_size;
  logic [5:0]  master_d_source;
  logic [2:0]  master_d_sink, master_d_error;
  logic [95:0] master_d_data;
  logic        slave_a_valid, slave_a_ready;
  logic [2:0]  slave_a_opcode, slave_a_param, slave_a_size;
  logic [1:0]  slave_a_source;
  logic [31:0] slave_a_address, slave_a_data;
  logic [3:0]  slave_a_mask;
  logic        slave_d_valid, slave_d_ready;
  logic [2:0]  slave_d_opcode, slave_d_param, slave_d_size;
  logic [1:0]  slave_d_source;
  logic        slave_d_sink, slave_d_error;
  logic [31:0] slave_d_data;

  always #5 clk_100 = ~clk_100;

  tlul_interconnect dut (
    .clk_100(clk_100), .reset(reset),
    .master_a_valid(master_a_valid), .master_a_ready(master_a_ready),
    .master_a_opcode(master_a_opcode), .master_a_param(master_a_param),
    .master_a_size(master_a_size), .master_a_source(master_a_source),
    .master_a_address(master_a_address), .master_a_mask(master_a_mask),
    .master_a_data(master_a_data),
    .master_d_valid(master_d_valid), .master_d_ready(master_d_ready),
    .master_d_opcode(master_d_opcode), .master_d_param(master_d_param),
    .master_d_size(master_d_size), .master_d_source(master_d_source),
    .master_d_sink(master_d_sink), .master_d_data(master_d_data),
    .master_d_error(master_d_error),
    .slave_a_valid(slave_a_valid), .slave_a_ready(slave_a_ready),
    .slave_a_opcode(slave_a_opcode), .slave_a_param(slave_a_param),
    .slave_a_size(slave_a_size), .slave_a_source(slave_a_source),
    .slave_a_address(slave_a_address), .slave_a_mask(slave_a_mask),
    .slave_a_data(slave_a_data),
    .slave_d_valid(slave_d_valid), .slave_d_ready(slave_d_ready),
    .slave_d_opcode(slave_d_opcode), .slave_d_param(slave_d_param),
    .slave_d_size(slave_d_size), .slave_d_source(slave_d_source),
    .slave_d_sink(slave_d_sink), .slave_d_data(slave_d_data),
    .slave_d_error(slave_d_error)
  );

  typedef struct {
    int          m;
    logic [2:0]  op;
    logic        err;
    logic        sink;
    logic [31:0] data;
    logic [1:0]  src;
    logic [2:0]  size;
  } d_exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  src;
    logic [2:0]  size;
    logic [3:0]  mask;
  } a_exp_t;

  d_exp_t d_q[$];
  d_exp_t s_q[$];
  a_exp_t a_q[$];
  bit     pend_hit [3];
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input int m, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] dat, input logic [1:0] src, input logic [2:0] sz,
                         input logic [3:0] msk, input logic [31:0] rsp_data, input bit track);
    a_exp_t ea;
    d_exp_t ed;
    bit     hit;
    master_a_opcode[m*3 +: 3]   = op;
    master_a_param[m*3 +: 3]    = 3'd0;
    master_a_size[m*3 +: 3]     = sz;
    master_a_source[m*2 +: 2]   = src;
    master_a_address[m*32 +: 32] = addr;
    master_a_mask[m*4 +: 4]     = msk;
    master_a_data[m*32 +: 32]   = dat;
    master_a_valid[m]           = 1'b1;
    hit = ((addr & 32'hFFFF_F000) == 32'h0) && (op == 3'd0 || op == 3'd1 || op == 3'd4);
    pend_hit[m] = hit;
    ed.m    = m;
    ed.op   = (op == 3'd4) ? 3'd1 : 3'd0;
    ed.size = sz;
    ed.src  = src;
    if (hit) begin
      ea.op = op; ea.addr = addr; ea.data = dat; ea.src = src; ea.size = sz; ea.mask = msk;
      a_q.push_back(ea);
      ed.err = 1'b0; ed.sink = 1'b1; ed.data = rsp_data;
      if (track) s_q.push_back(ed);
    end else begin
      ed.err = 1'b1; ed.sink = 1'b0; ed.data = 32'h0;
    end
    if (track) d_q.push_back(ed);
    #1;
  endtask

  task automatic wait_a_accept(input int m);
    logic [2:0] onehot;
    int n = 0;
    onehot = '0;
    onehot[m] = 1'b1;
    while (master_a_ready == 3'b000 && n < 40) begin
      @(negedge clk_100); #1;
      n++;
    end
    chk("a_grant", master_a_ready, onehot);
    if (master_a_ready == 3'b000) return;
    @(posedge clk_100); #1;
    master_a_valid[m] = 1'b0;
    @(negedge clk_100);
    if (pend_hit[m]) begin
      chk("hit_slave_a_valid_t1", slave_a_valid, 1);
      chk("hit_no_master_d", master_d_valid, 0);
    end else begin
      chk("miss_master_d_valid_t1", master_d_valid, onehot);
      chk("miss_no_slave_a", slave_a_valid, 0);
    end
  endtask

  task automatic check_a(input string tag, input a_exp_t e);
    chk({tag, "_opcode"}, slave_a_opcode, e.op);
    chk({tag, "_address"}, slave_a_address, e.addr);
    chk({tag, "_data"}, slave_a_data, e.data);
    chk({tag, "_source"}, slave_a_source, e.src);
    chk({tag, "_size"}, slave_a_size, e.size);
    chk({tag, "_mask"}, slave_a_mask, e.mask);
  endtask

  task automatic check_d(input string tag, input d_exp_t e);
    logic [2:0] onehot;
    onehot = '0;
    onehot[e.m] = 1'b1;
    chk({tag, "_valid"}, master_d_valid, onehot);
    chk({tag, "_opcode"}, master_d_opcode, 9'(e.op) << (3 * e.m));
    chk({tag, "_param"}, master_d_param, 0);
    chk({tag, "_size"}, master_d_size, 9'(e.size) << (3 * e.m));
    chk({tag, "_source"}, master_d_source, 6'(e.src) << (2 * e.m));
    chk({tag, "_sink"}, master_d_sink, 3'(e.sink) << e.m);
    chk({tag, "_data"}, master_d_data, 96'(e.data) << (32 * e.m));
    chk({tag, "_error"}, master_d_error, 3'(e.err) << e.m);
  endtask

  task automatic slave_serve(input int stall, input bit respond);
    a_exp_t ea;
    d_exp_t sr;
    int n = 0;
    while (!slave_a_valid && n < 40) begin
      @(negedge clk_100);
      n++;
    end
    if (a_q.size() == 0) begin
      chk("slave_a_unexpected", slave_a_valid, 0);
      return;
    end
    ea = a_q.pop_front();
    chk("slave_a_valid", slave_a_valid, 1);
    check_a("slave_a", ea);
    if (!slave_a_valid) return;
    repeat (stall) begin
      @(posedge clk_100); #1;
      @(negedge clk_100);
      chk("slave_a_hold_valid", slave_a_valid, 1);
      check_a("slave_a_hold", ea);
    end
    @(posedge clk_100); #1 slave_a_ready = 1'b1;
    @(posedge clk_100); #1 slave_a_ready = 1'b0;
    @(negedge clk_100);
    chk("slave_a_drop", slave_a_valid, 0);
    chk("slave_d_ready_rise", slave_d_ready, 1);
    if (!respond || s_q.size() == 0) return;
    sr = s_q.pop_front();
    slave_d_valid  = 1'b1;
    slave_d_opcode = sr.op;
    slave_d_param  = 3'd0;
    slave_d_size   = sr.size;
    slave_d_source = sr.src;
    slave_d_sink   = sr.sink;
    slave_d_data   = sr.data;
    slave_d_error  = sr.err;
    @(posedge clk_100); #1 slave_d_valid = 1'b0;
    @(negedge clk_100);
    chk("slave_d_ready_drop", slave_d_ready, 0);
    chk("master_d_after_slave_d", master_d_valid != 3'b000, 1);
  endtask

  task automatic master_collect(input int stall);
    d_exp_t e;
    int n = 0;
    while (master_d_valid == 3'b000 && n < 40) begin
      @(negedge clk_100);
      n++;
    end
    if (d_q.size() == 0) begin
      chk("master_d_unexpected", master_d_valid, 0);
      return;
    end
    e = d_q.pop_front();
    check_d("master_d", e);
    if (master_d_valid == 3'b000) return;
    repeat (stall) begin
      @(posedge clk_100); #1;
      @(negedge clk_100);
      check_d("master_d_hold", e);
    end
    @(posedge clk_100); #1 master_d_ready[e.m] = 1'b1;
    @(posedge clk_100); #1 master_d_ready[e.m] = 1'b0;
    @(negedge clk_100);
    chk("master_d_drop", master_d_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    master_a_valid = '0; master_a_opcode = '0; master_a_param = '0; master_a_size = '0;
    master_a_source = '0; master_a_address = '0; master_a_mask = '0; master_a_data = '0;
    master_d_ready = '0; slave_a_ready = 1'b0; slave_d_valid = 1'b0;
    slave_d_opcode = '0; slave_d_param = '0; slave_d_size = '0; slave_d_source = '0;
    slave_d_sink = 1'b0; slave_d_data = '0; slave_d_error = 1'b0;

    repeat (3) @(posedge clk_100);
    #1;
    chk("reset_slave_a_valid", slave_a_valid, 0);
    chk("reset_slave_d_ready", slave_d_ready, 0);
    chk("reset_master_d_valid", master_d_valid, 0);
    chk("reset_master_a_ready", master_a_ready, 0);
    chk("reset_slave_a_address", slave_a_address, 0);
    reset = 1'b1;
    @(negedge clk_100);

    // Get hit, slave returns data.
    drive_a(0, 3'd4, 32'h0000_0040, 32'h0, 2'd1, 3'd2, 4'hF, 32'hDEAD_BEEF, 1'b1);
    wait_a_accept(0);
    slave_serve(0, 1'b1);
    master_collect(0);

    // Decode miss just past the window, then illegal opcode inside it.
    drive_a(0, 3'd4, 32'h0000_1000, 32'h0, 2'd2, 3'd2, 4'hF, 32'h0, 1'b1);
    wait_a_accept(0);
    master_collect(0);
    drive_a(1, 3'd2, 32'h0000_0080, 32'h5555_AAAA, 2'd3, 3'd1, 4'h3, 32'h0, 1'b1);
    wait_a_accept(1);
    master_collect(0);

    // Last word of the window is a hit.
    drive_a(2, 3'd4, 32'h0000_0FFC, 32'h0, 2'd0, 3'd2, 4'hF, 32'h0BAD_F00D, 1'b1);
    wait_a_accept(2);
    slave_serve(0, 1'b1);
    master_collect(0);

    // PutFull with slave A backpressure, PutPartial with master D backpressure.
    drive_a(1, 3'd0, 32'h0000_0100, 32'hCAFE_BABE, 2'd2, 3'd2, 4'hF, 32'h0, 1'b1);
    wait_a_accept(1);
    slave_serve(5, 1'b1);
    master_collect(0);
    drive_a(2, 3'd1, 32'h0000_0200, 32'h1234_5678, 2'd3, 3'd2, 4'h3, 32'h0, 1'b1);
    wait_a_accept(2);
    slave_serve(0, 1'b1);
    master_collect(3);

    // Round-robin: all three request from reset; master 0 re-requests while 1 is served.
    reset = 1'b0;
    drive_a(0, 3'd4, 32'h0000_2000, 32'h0, 2'd0, 3'd2, 4'hF, 32'h0, 1'b1);
    drive_a(1, 3'd0, 32'h0000_3000, 32'h1111_2222, 2'd1, 3'd2, 4'hF, 32'h0, 1'b1);
    drive_a(2, 3'd4, 32'hFFFF_0000, 32'h0, 2'd2, 3'd1, 4'hF, 32'h0, 1'b1);
    chk("rr_ready_in_reset", master_a_ready, 0);
    @(posedge clk_100); #1 reset = 1'b1;
    @(negedge clk_100);
    wait_a_accept(0);
    master_collect(0);
    wait_a_accept(1);
    drive_a(0, 3'd5, 32'h0000_0010, 32'h0, 2'd3, 3'd0, 4'h1, 32'h0, 1'b1);
    master_collect(0);
    wait_a_accept(2);
    master_collect(0);
    wait_a_accept(0);
    master_collect(0);

    // Reset while waiting for the slave D response; pointer sits at master 1.
    drive_a(0, 3'd4, 32'h0000_0044, 32'h0, 2'd1, 3'd2, 4'hF, 32'h0, 1'b0);
    wait_a_accept(0);
    slave_serve(0, 1'b0);
    drive_a(1, 3'd4, 32'h0000_4000, 32'h0, 2'd1, 3'd2, 4'hF, 32'h0, 1'b1);
    drive_a(0, 3'd0, 32'h0000_5000, 32'h0, 2'd2, 3'd2, 4'hF, 32'h0, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("midrst_slave_d_ready", slave_d_ready, 0);
    chk("midrst_master_a_ready", master_a_ready, 0);
    chk("midrst_master_d_valid", master_d_valid, 0);
    chk("midrst_slave_a_valid", slave_a_valid, 0);
    chk("midrst_slave_a_address", slave_a_address, 0);
    @(posedge clk_100); #1 reset = 1'b1;
    @(negedge clk_100);
    // d_q holds master 1 then master 0; master 0 must win, so pop accordingly.
    begin
      d_exp_t first_rsp;
      first_rsp = d_q.pop_front();
      d_q.push_back(first_rsp);
    end
    wait_a_accept(0);
    master_collect(0);
    wait_a_accept(1);
    master_collect(0);

    chk("queues_empty", d_q.size() + a_q.size() + s_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlul_interconnect.md
# tlul_interconnect

Single-clock TileLink-UL (TL-UL) 3:1 interconnect between three upstream master sockets and one downstream slave socket. It arbitrates master A-channel requests round-robin and decodes the address against one slave window. Hits are forwarded downstream; misses get a local error response. Each D-channel response is routed back to the granted master. One transaction is outstanding at a time.

## Interface
- NUM_MASTERS, 3, number of master sockets (fixed at 3)
- ADDR_WIDTH / DATA_WIDTH, 32 / 32, address and data widths
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width
- SIZE_WIDTH / SRC_WIDTH / SINK_WIDTH, 3 / 2 / 1, TL size, source and sink field widths
- OPCODE_WIDTH / PARAM_WIDTH, 3 / 3, opcode and param widths
- SLAVE_BASE / SLAVE_MASK, 32'h0000_0000 / 32'hFFFF_F000, decode window: hit when (address & SLAVE_MASK) == SLAVE_BASE

Master-side ports are packed per master, with master i in bits [i*W +: W].

- clk_100 in 1: sole clock, rising edge
- reset in 1: asynchronous, active-low reset
- master_a_valid / master_a_ready, in / out, 3: A handshake per master
- master_a_opcode / param / size / source / address / mask / data, in, 3×field width: A fields
- master_d_valid out 3, master_d_ready in 3: D handshake per master
- master_d_opcode / param / size / source / sink / data, out, 3×field width: D fields
- master_d_error out 3: D error flag per master
- slave_a_valid out 1, slave_a_ready in 1: downstream A handshake
- slave_a_opcode / param / size / source / address / mask / data, out, single field width: downstream A fields
- slave_d_valid in 1, slave_d_ready out 1: downstream D handshake
- slave_d_opcode / param / size / source / sink / data / error, in, single field width: downstream D fields

## Operation
- FSM states: IDLE, ISSUE, WAIT_D, RESP.
- **IDLE:**
  - The arbiter picks one requesting master (grant g).
  - master_a_ready[g] is driven combinationally high for that cycle only; that cycle is the handshake.
  - All A fields of g are captured, plus g itself.
  - On a decode hit with a legal opcode (0 PutFullData, 1 PutPartialData, 4 Get), go to ISSUE.
  - Otherwise build an error response locally and go to RESP.
- **ISSUE:** drive slave_a_* from the captured request, with source passed through unchanged. On slave_a_ready, go to WAIT_D.
- **WAIT_D:** slave_d_ready=1. On slave_d_valid, capture all D fields and go to RESP.
- **RESP:**
  - master_d_valid[g]=1, with captured fields in slice g; all other slices are zero.
  - On master_d_ready[g], go to IDLE.
- **Error response:**
  - opcode is AccessAckData (1) for Get, otherwise AccessAck (0).
  - error=1, data=0, sink=0, param=0.
  - size and source are echoed from the request.
- **Arbitration:**
  - Round-robin priority pointer, reset to master 0.
  - After a grant to i, the pointer moves to (i+1) mod 3.
  - The pointer updates only on a grant.
- master_a_ready is 0 in every state except IDLE, so requests made while busy wait.

## Timing
- Every output and all internal registers reset to 0 asynchronously; FSM goes to IDLE and the pointer to 0.
- Reset mid-transaction abandons the transaction: no D response is produced.
- **Hit path:**
  - A accepted at cycle T.
  - slave_a_valid rises at T+1 and is held until slave_a_ready.
  - slave_d_ready rises the cycle after slave_a handshake.
  - master_d_valid rises the cycle after the slave_d handshake.
- **Miss / illegal opcode:** A accepted at T, master_d_valid[g] at T+1.
- All valid signals are held, with fields stable, until their ready is seen; they drop the cycle after the handshake.
- Back-to-back: IDLE is re-entered the cycle after the master_d handshake, so the next grant can occur then.
- Simultaneous valids from all three masters are served in pointer order, one per transaction.

## Structure
- Shared package tlul_pkg holds:
  - opcode constants: PutFullData=0, PutPartialData=1, Get=4, AccessAck=0, AccessAckData=1
  - FSM state enum
- One sub-module: tlul_rr_arbiter (3-way round-robin, request vector in, one-hot grant out, advance on accept).
- The top holds decode, capture registers, FSM and D routing.

## Test plan
- **Get hit:** master 0 issues Get at 0x0000_0040, size 2, source 1. Slave answers AccessAckData with data 0xDEAD_BEEF, error 0 → master_d_valid[0] with opcode 1, data 0xDEAD_BEEF, source 1.
- **Decode miss:** master 0 issues Get at 0x0000_1000 → no slave_a_valid; at T+1 master_d_valid[0] with opcode 1, error 1, data 0.
- **PutFull then PutPartial:**
  - master 1 issues PutFullData 0xCAFEBABE at 0x0000_0100 → slave_a sees opcode 0 and that data.
  - master 2 issues PutPartialData 0x12345678 at 0x0000_0200 → slave_a sees opcode 1 and that data.
  - Each receives AccessAck (opcode 0) in its own slice only.
- **Round-robin:** all three masters hold valid from reset → grants in order 0, 1, 2, then 0 again if 0 re-requests.
- **Backpressure:**
  - slave_a_ready held low 5 cycles → slave_a fields stable throughout.
  - master_d_ready[g] low 3 cycles → master_d fields held.
- **Reset mid-operation:** assert reset (low) in WAIT_D → all outputs go to 0 at once; after release, a new request gets a grant from master 0 priority.
